// File: rtl/dac_player_pkg.sv
// Shared definitions for the DAC playback path: default widths, FSM states
// and a helper telling which states count as busy.
package dac_player_pkg;

  localparam int ADDR_W_DEF = 18;
  localparam int DATA_W_DEF = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRIME,
    S_WAIT_FRAME,
    S_PLAY,
    S_DONE
  } state_e;

  function automatic logic is_busy(state_e s);
    return (s == S_PRIME) || (s == S_WAIT_FRAME) || (s == S_PLAY);
  endfunction

endpackage

// File: rtl/dac_serializer.sv
// Per-slot shift register for DACDAT. A load emits the first bit of the new
// word on the very next edge, so a slot never finishes an older word's bits.
module dac_serializer #(
  parameter int DATA_W    = 16,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic              bclk_i,
  input  logic              rst_i,
  input  logic              load_i,
  input  logic [DATA_W-1:0] load_val_i,
  input  logic              clear_i,
  output logic              bit_o
);

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_W);

  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              bit_q, bit_d;
  logic [DATA_W-1:0] src, rest;
  logic              head;

  always_comb begin
    src = load_i ? load_val_i : shreg_q;
    if (MSB_FIRST) begin
      head = src[DATA_W-1];
      rest = {src[DATA_W-2:0], 1'b0};
    end else begin
      head = src[0];
      rest = {1'b0, src[DATA_W-1:1]};
    end

    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    bit_d   = 1'b0;
    if (clear_i) begin
      shreg_d = '0;
      cnt_d   = '0;
    end else if (load_i) begin
      // cnt counts bits already driven, including the one emitted on load
      bit_d   = head;
      shreg_d = rest;
      cnt_d   = CNT_W'(1);
    end else if (cnt_q < CNT_FULL) begin
      bit_d   = head;
      shreg_d = rest;
      cnt_d   = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge bclk_i) begin
    if (rst_i) begin
      shreg_q <= '0;
      cnt_q   <= '0;
      bit_q   <= 1'b0;
    end else begin
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
    end
  end

  assign bit_o = bit_q;

endmodule

// File: rtl/dac_player.sv
// SRAM-to-codec playback: fetches one sample per frame, frames it with DACLRC
// and releases the shared address bus whenever play is low.
module dac_player
  import dac_player_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter bit MSB_FIRST  = 1'b0,
  parameter bit STEREO_DUP = 1'b1
) (
  input  logic              bclk_i,
  input  logic              rst_i,
  input  logic              daclrc_i,
  input  logic              play_i,
  input  logic [ADDR_W-1:0] end_addr_i,
  input  logic [DATA_W-1:0] sram_dq_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic              read_o,
  output logic              dacdat_o,
  output logic              busy_o,
  output logic              done_o
);

  state_e            state_q, state_d;
  logic [1:0]        lrc_q, lrc_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] sample_q, sample_d;
  logic              last_q, last_d;    // sample at end_addr has been fetched
  logic              pend_q, pend_d;    // that sample is the one now playing
  logic              fetch_q, fetch_d;  // read issued last cycle, capture now
  logic              done_q, done_d;
  logic              fall, rise;
  logic              ser_load, ser_clear;
  logic [DATA_W-1:0] ser_val;

  assign lrc_d = {lrc_q[0], daclrc_i};
  assign fall  = (lrc_q == 2'b10);
  assign rise  = (lrc_q == 2'b01);

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    sample_d = sample_q;
    last_d   = last_q;
    pend_d   = pend_q;
    fetch_d  = 1'b0;
    read_o   = 1'b0;
    ser_load = 1'b0;
    ser_val  = sample_q;

    if (!play_i) begin
      state_d = S_IDLE;
      addr_d  = '0;
      last_d  = 1'b0;
      pend_d  = 1'b0;
    end else begin
      if (fetch_q) begin
        sample_d = sram_dq_i;
        // Park on end_addr rather than wrapping back to zero
        if (addr_q == end_addr_i) last_d = 1'b1;
        else                      addr_d = addr_q + ADDR_W'(1);
      end

      case (state_q)
        S_IDLE: begin
          addr_d  = '0;
          last_d  = 1'b0;
          pend_d  = 1'b0;
          state_d = S_PRIME;
        end
        S_PRIME: begin
          if (fetch_q) begin
            state_d = S_WAIT_FRAME;
          end else begin
            read_o  = 1'b1;
            fetch_d = 1'b1;
          end
        end
        S_WAIT_FRAME: begin
          if (fall) begin
            ser_load = 1'b1;
            pend_d   = last_q;
            state_d  = S_PLAY;
          end
        end
        S_PLAY: begin
          if (fall) begin
            if (pend_q) begin
              state_d = S_DONE;
            end else begin
              ser_load = 1'b1;
              pend_d   = last_q;
            end
          end else if (rise) begin
            ser_load = 1'b1;
            ser_val  = STEREO_DUP ? sample_q : '0;
            // Prefetch next frame's sample while the right slot plays
            if (!last_q) begin
              read_o  = 1'b1;
              fetch_d = 1'b1;
            end
          end
        end
        S_DONE: ;
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign ser_clear = (state_d != S_PLAY);
  assign done_d    = (state_d == S_DONE) && (state_q != S_DONE);

  always_ff @(posedge bclk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      lrc_q    <= '0;
      addr_q   <= '0;
      sample_q <= '0;
      last_q   <= 1'b0;
      pend_q   <= 1'b0;
      fetch_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      lrc_q    <= lrc_d;
      addr_q   <= addr_d;
      sample_q <= sample_d;
      last_q   <= last_d;
      pend_q   <= pend_d;
      fetch_q  <= fetch_d;
      done_q   <= done_d;
    end
  end

  dac_serializer #(
    .DATA_W   (DATA_W),
    .MSB_FIRST(MSB_FIRST)
  ) u_ser (
    .bclk_i    (bclk_i),
    .rst_i     (rst_i),
    .load_i    (ser_load),
    .load_val_i(ser_val),
    .clear_i   (ser_clear),
    .bit_o     (dacdat_o)
  );

  assign addr_o = play_i ? addr_q : 'z;
  assign busy_o = is_busy(state_q);
  assign done_o = done_q;

endmodule
